// File: rtl/countdown_unit.sv
// Loadable down-counter with a three-state FSM (IDLE/RUN/DONE).
// Every output is decoded from registered state only; nothing combinational reaches them from the inputs.
module countdown_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is kept as a named signal so external checkers can bind to it.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH:0]   dec_sum;
  logic [WIDTH-1:0] count_dec;
  logic             load_nonzero;
  logic             count_is_one;
  logic             count_is_zero;

  // Decrement is an add of all-ones; the carry-out in bit WIDTH is dropped.
  assign dec_sum       = {1'b0, count_q} + {1'b0, {WIDTH{1'b1}}};
  assign count_dec     = dec_sum[WIDTH-1:0];
  assign load_nonzero  = (load_val != '0);
  assign count_is_one  = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});
  assign count_is_zero = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count_q <= '0;
    end else begin
      state   <= state_next;
      count_q <= count_next;
    end
  end

  // Priority on every edge: abort, then load, then en.
  always_comb begin
    state_next = state;
    count_next = count_q;
    if (abort) begin
      state_next = IDLE;
      count_next = '0;
    end else if (load) begin
      if (load_nonzero) begin
        state_next = RUN;
        count_next = load_val;
      end else begin
        state_next = DONE;
        count_next = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state_next = IDLE;
        end
        RUN: begin
          if (en) begin
            if (count_is_zero) begin
              // Unreachable in normal operation; finish rather than wrap.
              state_next = DONE;
            end else begin
              count_next = count_dec;
              if (count_is_one) begin
                state_next = DONE;
              end
            end
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign zero  = count_is_zero;

  a_done_means_zero : assert property (
    @(posedge clk) disable iff (!rst_n) done |-> (count == '0)
  );

  a_busy_means_nonzero : assert property (
    @(posedge clk) disable iff (!rst_n) busy |-> (count != '0)
  );

  a_done_one_cycle : assert property (
    @(posedge clk) disable iff (!rst_n) (done && !load) |=> !done
  );

endmodule

// File: tb/tb_countdown_unit.sv
// Scoreboard bench for countdown_unit: a driver pushes expected outputs computed
// by an arithmetic reference model; a monitor pops and compares after each edge.
module tb_countdown_unit;
  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             done;

  int total;
  int bad;
  int cyc;

  // Expected entry: {count, busy, zero, done}
  logic [EW-1:0] exp_q[$];

  // Reference model state
  int m_cnt;
  bit m_run;
  bit m_done;

  countdown_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s (cycle %0d): actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_run  = 0;
    m_done = 0;
  endtask

  // Apply one edge's worth of inputs to the model, return expected outputs.
  task automatic model_step(input bit ld, input int lv, input bit e, input bit ab,
                            output logic [EW-1:0] exp_o);
    if (ab) begin
      m_cnt = 0; m_run = 0; m_done = 0;
    end else if (ld) begin
      m_cnt  = lv;
      m_run  = (lv != 0);
      m_done = (lv == 0);
    end else begin
      m_done = 0;
      if (m_run && e) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end
    exp_o = {m_cnt[WIDTH-1:0], m_run, (m_cnt == 0), m_done};
  endtask

  // driver
  task automatic drive(input bit ld, input int lv, input bit e, input bit ab);
    logic [EW-1:0] exp_v;
    @(negedge clk);
    load     = ld;
    load_val = lv[WIDTH-1:0];
    en       = e;
    abort    = ab;
    model_step(ld, lv, e, ab, exp_v);
    exp_q.push_back(exp_v);
  endtask

  task automatic async_reset();
    @(negedge clk);
    load = 0; en = 0; abort = 0;
    #2 rst_n = 1'b0;
    #1;
    check("reset count", count, 0);
    check("reset busy", busy, 0);
    check("reset zero", zero, 1);
    check("reset done", done, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count", count, e[EW-1:3]);
      check("busy",  busy,  e[2]);
      check("zero",  zero,  e[1]);
      check("done",  done,  e[0]);
    end
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; load = 0; load_val = '0; en = 0; abort = 0;
    model_reset();
    #1;
    check("por count", count, 0);
    check("por busy", busy, 0);
    check("por zero", zero, 1);
    check("por done", done, 0);
    #20 rst_n = 1'b1;

    // load 4, en held high: 4,3,2,1,0 with one done
    drive(1, 4, 1, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0);

    // load 3, en toggling
    drive(1, 3, 0, 0);
    drive(0, 0, 1, 0); drive(0, 0, 0, 0); drive(0, 0, 1, 0);
    drive(0, 0, 0, 0); drive(0, 0, 1, 0); drive(0, 0, 1, 0);

    // load of zero goes straight to DONE
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);

    // reload mid-run, then abort+load together at 7
    drive(1, 9, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    drive(1, 2, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    drive(1, 9, 1, 0);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);
    drive(1, 5, 1, 1);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);

    // reset in the middle of a countdown
    drive(1, 9, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    async_reset();
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);

    // reload of 15 in the DONE cycle
    drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 15, 1, 0);
    for (int i = 0; i < 18; i++) drive(0, 0, 1, 0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      bit ld, e, ab;
      int lv;
      ld = ($urandom_range(0, 11) == 0);
      ab = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 9) < 7);
      lv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      drive(ld, lv, e, ab);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    @(negedge clk);
    load = 0; en = 0; abort = 0;
    @(negedge clk);
    check("queue drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
